// File: rtl/alu_decode_stage.sv
// alu_decode_stage
//   D->E pipeline register plus main/ALU decoder for an RV64I + Zba execute ALU.
//   Each cycle the instruction in decode is decoded and, unless the E register
//   is stalled or flushed, loaded into E. A one-bit halt FSM stops issue after
//   an illegal encoding has been loaded into E; only reset leaves HALT.
// Ports
//   clk, rst_n           clock, async active-low reset
//   InstrD, ValidD       decode-stage instruction word and its valid flag
//   StallE, FlushE       hold / bubble control for the E register
//   ValidE..IllegalE     registered E-side decode results
//   HaltD                block halted, decode must stop fetching
module alu_decode_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] InstrD,
  input  logic        ValidD,
  input  logic        StallE,
  input  logic        FlushE,
  output logic        ValidE,
  output logic [3:0]  ALUControlE,
  output logic [2:0]  funct3E,
  output logic        ALUSrcE,
  output logic [63:0] ImmExtE,
  output logic [4:0]  Rs1E,
  output logic [4:0]  Rs2E,
  output logic [4:0]  RdE,
  output logic        RegWriteE,
  output logic        MemWriteE,
  output logic        BranchE,
  output logic        IllegalE,
  output logic        HaltD
);

  localparam logic [3:0] ALU_ADD = 4'b0000, ALU_SUB = 4'b0001, ALU_AND = 4'b0010,
                         ALU_OR  = 4'b0011, ALU_SLT = 4'b0100, ALU_XOR = 4'b0101,
                         ALU_ADDUW = 4'b1011;

  localparam logic [6:0] OPC_OP = 7'b0110011, OPC_OP32 = 7'b0111011, OPC_OPIMM = 7'b0010011,
                         OPC_LOAD = 7'b0000011, OPC_STORE = 7'b0100011, OPC_BRANCH = 7'b1100011;

  typedef struct packed {
    logic        valid;
    logic [3:0]  alu;
    logic [2:0]  f3;
    logic        src;
    logic [63:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        rw;
    logic        mw;
    logic        br;
    logic        ill;
  } ereg_t;

  typedef enum logic {S_RUN, S_HALT} state_t;

  state_t state_q, state_d;
  ereg_t  e_q, e_d, dec;

  logic [6:0] opc;
  logic [6:0] f7;
  logic [2:0] f3;
  logic [3:0] base_alu;
  logic       base_ok;
  logic       issue;

  assign opc = InstrD[6:0];
  assign f7  = InstrD[31:25];
  assign f3  = InstrD[14:12];

  // funct3 -> ALU op shared by OP (funct7=0) and OP-IMM
  always_comb begin
    base_alu = ALU_ADD;
    base_ok  = 1'b1;
    case (f3)
      3'b000:  base_alu = ALU_ADD;
      3'b010:  base_alu = ALU_SLT;
      3'b100:  base_alu = ALU_XOR;
      3'b110:  base_alu = ALU_OR;
      3'b111:  base_alu = ALU_AND;
      default: base_ok  = 1'b0;
    endcase
  end

  // Default is the illegal decode: ADD, no controls, zero immediate.
  // funct3 and register fields always pass through.
  always_comb begin
    dec       = '0;
    dec.valid = 1'b1;
    dec.f3    = f3;
    dec.rs1   = InstrD[19:15];
    dec.rs2   = InstrD[24:20];
    dec.rd    = InstrD[11:7];
    dec.ill   = 1'b1;
    case (opc)
      OPC_OP: begin
        if (f7 == 7'b0000000 && base_ok) begin
          dec.alu = base_alu; dec.rw = 1'b1; dec.ill = 1'b0;
        end else if (f7 == 7'b0100000 && f3 == 3'b000) begin
          dec.alu = ALU_SUB; dec.rw = 1'b1; dec.ill = 1'b0;
        end else if (f7 == 7'b0010000 && (f3 == 3'b010 || f3 == 3'b100 || f3 == 3'b110)) begin
          // SH1ADD/SH2ADD/SH3ADD = 1000/1001/1010 follow funct3[2:1] = 01/10/11
          dec.alu = {2'b10, f3[2:1] - 2'd1}; dec.rw = 1'b1; dec.ill = 1'b0;
        end
      end
      OPC_OP32: begin
        if (f7 == 7'b0000100 && f3 == 3'b000) begin
          dec.alu = ALU_ADDUW; dec.rw = 1'b1; dec.ill = 1'b0;
        end
      end
      OPC_OPIMM: begin
        if (base_ok) begin
          dec.alu = base_alu; dec.rw = 1'b1; dec.src = 1'b1; dec.ill = 1'b0;
          dec.imm = {{52{InstrD[31]}}, InstrD[31:20]};
        end
      end
      OPC_LOAD: begin
        dec.rw = 1'b1; dec.src = 1'b1; dec.ill = 1'b0;
        dec.imm = {{52{InstrD[31]}}, InstrD[31:20]};
      end
      OPC_STORE: begin
        dec.mw = 1'b1; dec.src = 1'b1; dec.ill = 1'b0;
        dec.imm = {{52{InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
      end
      OPC_BRANCH: begin
        dec.alu = ALU_SUB; dec.br = 1'b1; dec.ill = 1'b0;
        dec.imm = {{51{InstrD[31]}}, InstrD[31], InstrD[7], InstrD[30:25], InstrD[11:8], 1'b0};
      end
      default: ;
    endcase
  end

  // A real load into E only happens in RUN, unstalled, unflushed, with ValidD
  assign issue = !FlushE && !StallE && ValidD && (state_q == S_RUN);

  always_comb begin
    if (FlushE)      e_d = '0;
    else if (StallE) e_d = e_q;
    else if (issue)  e_d = dec;
    else             e_d = '0;
  end

  always_comb begin
    state_d = state_q;
    if (issue && dec.ill) state_d = S_HALT;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_RUN;
      e_q     <= '0;
    end else begin
      state_q <= state_d;
      e_q     <= e_d;
    end
  end

  assign ValidE      = e_q.valid;
  assign ALUControlE = e_q.alu;
  assign funct3E     = e_q.f3;
  assign ALUSrcE     = e_q.src;
  assign ImmExtE     = e_q.imm;
  assign Rs1E        = e_q.rs1;
  assign Rs2E        = e_q.rs2;
  assign RdE         = e_q.rd;
  assign RegWriteE   = e_q.rw;
  assign MemWriteE   = e_q.mw;
  assign BranchE     = e_q.br;
  assign IllegalE    = e_q.ill;
  assign HaltD       = (state_q == S_HALT);

endmodule

// File: tb/tb_alu_decode_stage.sv
// Self-checking bench for alu_decode_stage: directed scenarios followed by
// randomized traffic compared against a table-driven reference model.
module tb_alu_decode_stage;

  logic        clk, rst_n;
  logic [31:0] InstrD;
  logic        ValidD, StallE, FlushE;
  logic        ValidE, ALUSrcE, RegWriteE, MemWriteE, BranchE, IllegalE, HaltD;
  logic [3:0]  ALUControlE;
  logic [2:0]  funct3E;
  logic [63:0] ImmExtE;
  logic [4:0]  Rs1E, Rs2E, RdE;

  alu_decode_stage dut (
    .clk(clk), .rst_n(rst_n), .InstrD(InstrD), .ValidD(ValidD), .StallE(StallE),
    .FlushE(FlushE), .ValidE(ValidE), .ALUControlE(ALUControlE), .funct3E(funct3E),
    .ALUSrcE(ALUSrcE), .ImmExtE(ImmExtE), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .BranchE(BranchE),
    .IllegalE(IllegalE), .HaltD(HaltD)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        v;
    logic [3:0]  alu;
    logic [2:0]  f3;
    logic        src;
    logic [63:0] imm;
    logic [4:0]  rs1, rs2, rd;
    logic        rw, mw, br, ill;
  } exp_t;

  // funct3 -> ALU code for OP / OP-IMM base ops; -1 marks unsupported funct3
  int RT [8] = '{0, -1, 4, -1, 5, -1, 3, 2};

  int   n_chk  = 0;
  int   n_fail = 0;
  exp_t m_e;
  bit   m_halt;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference decode: what each instruction word means
  function automatic exp_t mdl(input logic [31:0] w);
    exp_t e;
    logic [6:0] opc = w[6:0];
    logic [6:0] f7  = w[31:25];
    int         f3  = int'(w[14:12]);
    bit         ok  = 0;
    e = '0;
    e.v = 1; e.f3 = w[14:12]; e.rs1 = w[19:15]; e.rs2 = w[24:20]; e.rd = w[11:7];
    case (opc)
      7'h33: begin
        if (f7 == 7'h00 && RT[f3] >= 0) begin ok = 1; e.alu = 4'(RT[f3]); end
        else if (f7 == 7'h20 && f3 == 0) begin ok = 1; e.alu = 4'd1; end
        else if (f7 == 7'h10 && (f3 == 2 || f3 == 4 || f3 == 6)) begin ok = 1; e.alu = 4'(7 + f3 / 2); end
        e.rw = ok;
      end
      7'h3B: if (f7 == 7'h04 && f3 == 0) begin ok = 1; e.alu = 4'd11; e.rw = 1; end
      7'h13: if (RT[f3] >= 0) begin
        ok = 1; e.alu = 4'(RT[f3]); e.rw = 1; e.src = 1; e.imm = 64'($signed(w[31:20]));
      end
      7'h03: begin ok = 1; e.rw = 1; e.src = 1; e.imm = 64'($signed(w[31:20])); end
      7'h23: begin ok = 1; e.mw = 1; e.src = 1; e.imm = 64'($signed({w[31:25], w[11:7]})); end
      7'h63: begin
        ok = 1; e.alu = 4'd1; e.br = 1;
        e.imm = 64'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0}));
      end
      default: ;
    endcase
    e.ill = !ok;
    return e;
  endfunction

  function automatic exp_t dut_e();
    exp_t e;
    e = '{ValidE, ALUControlE, funct3E, ALUSrcE, ImmExtE, Rs1E, Rs2E, RdE,
          RegWriteE, MemWriteE, BranchE, IllegalE};
    return e;
  endfunction

  task automatic mreset();
    m_e = '0; m_halt = 0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_E"}, 128'(dut_e()), 128'(m_e));
    chk({tag, "_halt"}, 128'(HaltD), 128'(m_halt));
  endtask

  task automatic drive(input logic [31:0] w, input logic v, input logic s, input logic f);
    InstrD = w; ValidD = v; StallE = s; FlushE = f;
  endtask

  // One clock: advance the model on the current inputs, then compare after the edge
  task automatic cyc(input string tag);
    if (FlushE) m_e = '0;
    else if (StallE) ;
    else if (ValidD && !m_halt) begin
      m_e = mdl(InstrD);
      if (m_e.ill) m_halt = 1;
    end else m_e = '0;
    @(posedge clk); #1;
    check_all(tag);
  endtask

  function automatic logic [31:0] rnd_instr();
    logic [31:0] w = $urandom;
    logic [6:0]  f7s [4] = '{7'h00, 7'h20, 7'h10, 7'h00};
    case ($urandom_range(0, 9))
      0, 1: begin w[6:0] = 7'h33; w[31:25] = ($urandom_range(0, 7) == 0) ? 7'($urandom) : f7s[$urandom_range(0, 3)]; end
      2: begin w[6:0] = 7'h3B; w[31:25] = ($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'h04;
               if ($urandom_range(0, 1) == 0) w[14:12] = 3'b000; end
      3, 4: w[6:0] = 7'h13;
      5: w[6:0] = 7'h03;
      6: w[6:0] = 7'h23;
      7: w[6:0] = 7'h63;
      8: w = 32'h0;
      default: ;
    endcase
    return w;
  endfunction

  localparam logic [31:0] ADD_I = 32'h002081B3;

  initial begin
    rst_n = 1'b0; drive(32'h0, 0, 0, 0); mreset();
    #1 check_all("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    drive(ADD_I, 1, 0, 0); cyc("add");
    chk("add_v", 128'(ValidE), 128'(1));       chk("add_alu", 128'(ALUControlE), 128'(0));
    chk("add_src", 128'(ALUSrcE), 128'(0));    chk("add_rs1", 128'(Rs1E), 128'(1));
    chk("add_rs2", 128'(Rs2E), 128'(2));       chk("add_rd", 128'(RdE), 128'(3));
    chk("add_rw", 128'(RegWriteE), 128'(1));

    drive(32'h2020A1B3, 1, 0, 0); cyc("sh1add");
    chk("sh1add_alu", 128'(ALUControlE), 128'(4'b1000));
    drive(32'h082081BB, 1, 0, 0); cyc("adduw");
    chk("adduw_alu", 128'(ALUControlE), 128'(4'b1011));
    drive(32'hFFF00293, 1, 0, 0); cyc("addi");
    chk("addi_src", 128'(ALUSrcE), 128'(1));
    chk("addi_imm", 128'(ImmExtE), 128'(64'hFFFF_FFFF_FFFF_FFFF));
    drive(32'h00208463, 1, 0, 0); cyc("beq");
    chk("beq_alu", 128'(ALUControlE), 128'(1)); chk("beq_f3", 128'(funct3E), 128'(0));
    chk("beq_br", 128'(BranchE), 128'(1));      chk("beq_imm", 128'(ImmExtE), 128'(8));
    chk("beq_rw", 128'(RegWriteE), 128'(0));

    drive(ADD_I, 1, 0, 0); cyc("ld_add");
    for (int i = 0; i < 3; i++) begin
      drive($urandom, 1, 1, 0); cyc("stall");
      chk("stall_v", 128'(ValidE), 128'(1)); chk("stall_rd", 128'(RdE), 128'(3));
      chk("stall_alu", 128'(ALUControlE), 128'(0));
    end
    drive(ADD_I, 1, 1, 1); cyc("stallflush");
    chk("sf_v", 128'(ValidE), 128'(0));

    drive(32'h0, 1, 0, 0); cyc("illegal");
    chk("ill_ill", 128'(IllegalE), 128'(1)); chk("ill_v", 128'(ValidE), 128'(1));
    chk("ill_halt", 128'(HaltD), 128'(1));
    drive(ADD_I, 1, 1, 0); cyc("ill_stall");
    chk("ill_stall_ill", 128'(IllegalE), 128'(1));
    for (int i = 0; i < 2; i++) begin
      drive(ADD_I, 1, 0, 0); cyc("halted");
      chk("halted_v", 128'(ValidE), 128'(0));
    end
    #2 rst_n = 1'b0; mreset();
    #1 chk("arst_halt", 128'(HaltD), 128'(0)); chk("arst_v", 128'(ValidE), 128'(0));
    check_all("arst");
    #1 rst_n = 1'b1;
    drive(ADD_I, 1, 0, 0); cyc("post_rst");
    chk("post_rst_v", 128'(ValidE), 128'(1));

    // Illegal flushed on presentation or held by stall is lost: no halt
    drive(32'h0, 1, 0, 1); cyc("ill_flush");
    drive(32'h0, 1, 1, 0); cyc("ill_held");
    chk("ill_lost_halt", 128'(HaltD), 128'(0));

    drive(32'h0020B423, 1, 0, 0); cyc("sd");
    chk("sd_mw", 128'(MemWriteE), 128'(1));
    for (int i = 0; i < 2; i++) begin
      drive($urandom, 0, 0, 0); cyc("novalid");
      chk("nv_v", 128'(ValidE), 128'(0)); chk("nv_rw", 128'(RegWriteE), 128'(0));
      chk("nv_mw", 128'(MemWriteE), 128'(0));
    end

    for (int i = 0; i < 1500; i++) begin
      if ((m_halt && $urandom_range(0, 3) == 0) || $urandom_range(0, 49) == 0) begin
        #2 rst_n = 1'b0; mreset();
        #1 check_all("rnd_arst");
        #1 rst_n = 1'b1;
      end
      drive(rnd_instr(), $urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0,
            $urandom_range(0, 7) == 0);
      cyc("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_decode_stage.md
# alu_decode_stage

Decode-side producer for the RV64I + Zba execute ALU: registers one instruction per cycle from the decode stage and drives the ALU control code, branch funct3, immediate and register fields into the execute stage. It is the D→E pipeline register plus main/ALU decoder. A one-bit halt state machine stops issue after an illegal encoding.

## Interface
- No parameters; XLEN fixed at 64.
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- InstrD  input  32  instruction word in decode
- ValidD  input  1  InstrD holds a real instruction this cycle
- StallE  input  1  hold all E-side registers
- FlushE  input  1  load a bubble into E
- ValidE  output  1  E-side register holds a real instruction
- ALUControlE  output  4  ALU op code, encoding below
- funct3E  output  3  InstrD[14:12], used by branch compare
- ALUSrcE  output  1  1 = SrcB is ImmExtE, 0 = rs2
- ImmExtE  output  64  sign-extended immediate
- Rs1E, Rs2E, RdE  output  5 each  register fields
- RegWriteE, MemWriteE, BranchE  output  1 each  control
- IllegalE  output  1  E instruction was unsupported
- HaltD  output  1  block halted; decode must stop fetching

## Operation
- ALU codes: ADD 0000, SUB 0001, AND 0010, OR 0011, SLT 0100, XOR 0101, SH1ADD 1000, SH2ADD 1001, SH3ADD 1010, ADD.UW 1011.
- Opcode 0110011, funct7 0000000: funct3 000 ADD, 111 AND, 110 OR, 010 SLT, 100 XOR. funct7 0100000 with funct3 000 → SUB. funct7 0010000: funct3 010 SH1ADD, 100 SH2ADD, 110 SH3ADD. RegWrite=1, ALUSrc=0, ImmExt=0.
- Opcode 0111011, funct7 0000100, funct3 000 → ADD.UW. RegWrite=1, ALUSrc=0.
- Opcode 0010011: funct3 000 ADD, 010 SLT, 100 XOR, 110 OR, 111 AND. I-immediate is sign-extended {InstrD[31:20]}. RegWrite=1, ALUSrc=1.
- Opcode 0000011 (load): ADD, I-immediate, RegWrite=1, ALUSrc=1.
- Opcode 0100011 (store): ADD, S-immediate {InstrD[31:25],InstrD[11:7]}, MemWrite=1, ALUSrc=1, RegWrite=0.
- Opcode 1100011 (branch): SUB, B-immediate {InstrD[31],InstrD[7],InstrD[30:25],InstrD[11:8],1'b0}, Branch=1, RegWrite=0. funct3 is passed through unchanged.
- Every other encoding is illegal:
  - Illegal=1, ALUControl=ADD, all write/branch controls 0, ImmExt=0.
  - The illegal instruction is still issued with ValidE=1.
- FSM states:
  - RUN → HALT when a ValidD instruction with an illegal encoding is loaded into E.
  - HALT is held until reset.
  - In HALT, every cycle that is not stalled loads a bubble, and HaltD=1.

## Timing
- Latency is one cycle: the decode of InstrD at edge N is visible on the E outputs after edge N.
- Register update priority: FlushE > StallE > load.
  - FlushE=1: ValidE←0, RegWriteE/MemWriteE/BranchE/IllegalE←0. Other fields are don't-care and cleared to 0.
  - StallE=1, FlushE=0: all E outputs hold their values.
  - Otherwise, if ValidD=1 in RUN: decoded values load.
  - Otherwise: a bubble loads, identical to flush.
- An illegal instruction is lost, with no HALT transition, when it is:
  - flushed in the same cycle it is presented, or
  - held in D because StallE=1.
- Stall while an illegal instruction sits in E: HALT is already set, and IllegalE stays 1 until released.
- Reset mid-operation: all outputs are 0 immediately and asynchronously, state returns to RUN, and HaltD=0.
- Reset values: every output is 0, including ALUControlE=0000 and ValidE=0.

## Test plan
- Reset, then ValidD=1 with InstrD=0x002081B3 (add x3,x1,x2) → next cycle:
  - ValidE=1, ALUControlE=0000, ALUSrcE=0
  - Rs1E=1, Rs2E=2, RdE=3, RegWriteE=1
- Back-to-back stream with one instruction per cycle:
  - 0x2020A1B3 (sh1add) → ALUControlE=1000
  - 0x082081BB (add.uw) → ALUControlE=1011
  - 0xFFF00293 (addi x5,x0,-1) → ALUSrcE=1, ImmExtE=0xFFFFFFFFFFFFFFFF
- 0x00208463 (beq x1,x2,+8) → ALUControlE=0001, funct3E=000, BranchE=1, ImmExtE=8, RegWriteE=0.
- Load add, then assert StallE for 3 cycles while changing InstrD → E outputs unchanged. Assert StallE and FlushE together → ValidE=0 next cycle.
- InstrD=0x00000000, ValidD=1:
  - Next cycle: IllegalE=1, ValidE=1, HaltD=1.
  - Following valid adds yield ValidE=0.
  - Pulse rst_n low mid-cycle → HaltD=0 asynchronously, and a later add issues normally.
- ValidD=0 for 2 cycles → ValidE=0, RegWriteE=0, MemWriteE=0 on both cycles.
